// File: rtl/fp_to_axil_burst.sv
// FrontPanel wire/trigger/pipe endpoints driving an AXI-Lite master that runs counted
// single-beat bursts; write data comes from a pipe-in FIFO and read data goes to a pipe-out FIFO.

module fp_axil_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   // Extra pointer bit tells full from empty when the index bits match
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end
endmodule

module fp_to_axil_burst #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ADDR_WIDTH-1:0]   ep_addr,
   input  logic [15:0]             ep_count,
   input  logic                    ep_incr,
   input  logic [31:0]             ep_timeout,
   input  logic [31:0]             ep_trigger,
   output logic                    ep_trigger_clk,
   output logic [31:0]             ep_status,
   input  logic [DATA_WIDTH-1:0]   pi_data,
   input  logic                    pi_write,
   output logic [DATA_WIDTH-1:0]   po_data,
   input  logic                    po_read,
   output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
   output logic [2:0]              m_axil_awprot,
   output logic                    m_axil_awvalid,
   input  logic                    m_axil_awready,
   output logic [DATA_WIDTH-1:0]   m_axil_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
   output logic                    m_axil_wvalid,
   input  logic                    m_axil_wready,
   input  logic [1:0]              m_axil_bresp,
   input  logic                    m_axil_bvalid,
   output logic                    m_axil_bready,
   output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
   output logic [2:0]              m_axil_arprot,
   output logic                    m_axil_arvalid,
   input  logic                    m_axil_arready,
   input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
   input  logic [1:0]              m_axil_rresp,
   input  logic                    m_axil_rvalid,
   output logic                    m_axil_rready
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [2:0] {IDLE, W_ISSUE, W_RESP, R_ISSUE, R_DATA, DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             remain_q, remain_d;
   logic [15:0]             beats_q, beats_d;
   logic                    incr_q, incr_d;
   logic [31:0]             tmo_q, tmo_d;
   logic [31:0]             timer_q, timer_d;
   logic                    err_q, err_d;
   logic                    tmo_flag_q, tmo_flag_d;
   logic [1:0]              resp_q, resp_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    pi_ovf_q, pi_ovf_d;

   logic                    busy, idle_like, tmo_hit, fifo_flush;
   logic                    aw_fire, w_fire, b_fire, ar_fire, r_fire, beat_fire;
   logic [1:0]              beat_resp;
   logic [DATA_WIDTH-1:0]   pi_head;
   logic                    pi_full, pi_empty, po_full, po_empty;
   logic                    unused_trig;

   assign unused_trig    = ^ep_trigger[31:3];
   assign ep_trigger_clk = aclk;

   assign busy      = (state_q == W_ISSUE) || (state_q == W_RESP) ||
                      (state_q == R_ISSUE) || (state_q == R_DATA);
   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign tmo_hit   = busy && (tmo_q != 32'd0) && ((timer_q + 32'd1) == tmo_q);
   assign fifo_flush = idle_like && ep_trigger[2];

   // awvalid stays up after an early w handshake even if that pop emptied the FIFO
   assign m_axil_awvalid = (state_q == W_ISSUE) && !aw_done_q && (w_done_q || !pi_empty);
   assign m_axil_wvalid  = (state_q == W_ISSUE) && !w_done_q && !pi_empty;
   assign m_axil_bready  = (state_q == W_RESP);
   assign m_axil_arvalid = (state_q == R_ISSUE) && !po_full;
   assign m_axil_rready  = (state_q == R_DATA);
   assign m_axil_awaddr  = addr_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_wstrb   = '1;
   assign m_axil_wdata   = m_axil_wvalid ? pi_head : '0;

   assign aw_fire   = m_axil_awvalid && m_axil_awready;
   assign w_fire    = m_axil_wvalid && m_axil_wready;
   assign b_fire    = m_axil_bready && m_axil_bvalid;
   assign ar_fire   = m_axil_arvalid && m_axil_arready;
   assign r_fire    = m_axil_rready && m_axil_rvalid;
   assign beat_fire = b_fire || r_fire;
   assign beat_resp = b_fire ? m_axil_bresp : m_axil_rresp;

   assign ep_status = {beats_q, 7'd0, pi_ovf_q, po_empty, pi_full, resp_q,
                       tmo_flag_q, err_q, (state_q == DONE), busy};

   fp_axil_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_pi_fifo (
      .clk(aclk), .rst(areset), .flush(fifo_flush), .push(pi_write), .din(pi_data),
      .pop(w_fire), .dout(pi_head), .full(pi_full), .empty(pi_empty));

   fp_axil_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_po_fifo (
      .clk(aclk), .rst(areset), .flush(fifo_flush), .push(r_fire), .din(m_axil_rdata),
      .pop(po_read), .dout(po_data), .full(po_full), .empty(po_empty));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      beats_d    = beats_q;
      incr_d     = incr_q;
      tmo_d      = tmo_q;
      timer_d    = busy ? timer_q + 32'd1 : timer_q;
      err_d      = err_q;
      tmo_flag_d = tmo_flag_q;
      resp_d     = resp_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      pi_ovf_d   = pi_ovf_q || (pi_write && pi_full);

      case (state_q)
         IDLE, DONE: begin
            if (ep_trigger[2]) begin
               err_d      = 1'b0;
               tmo_flag_d = 1'b0;
               resp_d     = 2'b00;
               pi_ovf_d   = 1'b0;
               state_d    = IDLE;
            end
            if (ep_trigger[0] || ep_trigger[1]) begin
               addr_d    = ep_addr;
               remain_d  = ep_count;
               incr_d    = ep_incr;
               tmo_d     = ep_timeout;
               timer_d   = '0;
               beats_d   = '0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (ep_count == 16'd0)  state_d = DONE;
               else if (ep_trigger[0]) state_d = W_ISSUE;
               else                    state_d = R_ISSUE;
            end
         end
         W_ISSUE: begin
            aw_done_d = aw_done_q || aw_fire;
            w_done_d  = w_done_q || w_fire;
            if (aw_done_d && w_done_d) begin
               state_d   = W_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else if (tmo_hit) begin
               state_d    = DONE;
               tmo_flag_d = 1'b1;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
            end
         end
         R_ISSUE: begin
            if (ar_fire) begin
               state_d = R_DATA;
            end else if (tmo_hit) begin
               state_d    = DONE;
               tmo_flag_d = 1'b1;
            end
         end
         W_RESP, R_DATA: begin
            if (!beat_fire && tmo_hit) begin
               state_d    = DONE;
               tmo_flag_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A completed beat either ends the burst or re-issues from the matching issue state
      if (beat_fire) begin
         beats_d = beats_q + 16'd1;
         resp_d  = beat_resp;
         timer_d = '0;
         if (beat_resp != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
         end else begin
            if (incr_q) addr_d = addr_q + ADDR_STEP;
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1)     state_d = DONE;
            else if (state_q == W_RESP) state_d = W_ISSUE;
            else                       state_d = R_ISSUE;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         beats_q    <= '0;
         incr_q     <= 1'b0;
         tmo_q      <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         tmo_flag_q <= 1'b0;
         resp_q     <= 2'b00;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         pi_ovf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         beats_q    <= beats_d;
         incr_q     <= incr_d;
         tmo_q      <= tmo_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         tmo_flag_q <= tmo_flag_d;
         resp_q     <= resp_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         pi_ovf_q   <= pi_ovf_d;
      end
   end
endmodule

// File: tb/tb_fp_to_axil_burst.sv
// Directed bench for fp_to_axil_burst: bursts, FIFO backpressure, error, timeout, wrap and reset.

module tb_fp_to_axil_burst;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int FD = 4;

   logic          aclk, areset;
   logic [AW-1:0] ep_addr;
   logic [15:0]   ep_count;
   logic          ep_incr;
   logic [31:0]   ep_timeout, ep_trigger, ep_status;
   logic          ep_trigger_clk;
   logic [DW-1:0] pi_data, po_data;
   logic          pi_write, po_read;
   logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
   logic [2:0]    m_axil_awprot, m_axil_arprot;
   logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [DW-1:0] m_axil_wdata, m_axil_rdata;
   logic [DW/8-1:0] m_axil_wstrb;
   logic [1:0]    m_axil_bresp, m_axil_rresp;
   logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
   logic          m_axil_rvalid, m_axil_rready;

   int n_tests = 0;
   int n_fail  = 0;

   fp_to_axil_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .aclk(aclk), .areset(areset), .ep_addr(ep_addr), .ep_count(ep_count), .ep_incr(ep_incr),
      .ep_timeout(ep_timeout), .ep_trigger(ep_trigger), .ep_trigger_clk(ep_trigger_clk),
      .ep_status(ep_status), .pi_data(pi_data), .pi_write(pi_write), .po_data(po_data),
      .po_read(po_read), .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
      .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
      .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
      .m_axil_rready(m_axil_rready));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
      $fatal(1);
   end

   task automatic pulse(input logic [31:0] bits);
      ep_trigger = bits;
      @(negedge aclk);
      ep_trigger = '0;
   endtask

   task automatic push_pi(input logic [31:0] d);
      pi_data = d; pi_write = 1'b1;
      @(negedge aclk);
      pi_write = 1'b0;
   endtask

   task automatic pop_po(output logic [31:0] d);
      d = po_data; po_read = 1'b1;
      @(negedge aclk);
      po_read = 1'b0;
   endtask

   task automatic serve_write(input logic [1:0] resp, output logic [31:0] addr,
                              output logic [31:0] data, output logic br, output bit ok);
      ok = 0; addr = '0; data = '0; br = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (m_axil_awvalid && m_axil_wvalid) begin ok = 1; break; end
         @(negedge aclk);
      end
      if (ok) begin
         addr = m_axil_awaddr; data = m_axil_wdata;
         m_axil_awready = 1'b1; m_axil_wready = 1'b1;
         @(negedge aclk);
         m_axil_awready = 1'b0; m_axil_wready = 1'b0;
         br = m_axil_bready;
         m_axil_bvalid = 1'b1; m_axil_bresp = resp;
         @(negedge aclk);
         m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
      end
   endtask

   task automatic serve_read(input logic [31:0] data, output logic [31:0] addr, output bit ok);
      ok = 0; addr = '0;
      for (int i = 0; i < 50; i++) begin
         if (m_axil_arvalid) begin ok = 1; break; end
         @(negedge aclk);
      end
      if (ok) begin
         addr = m_axil_araddr;
         m_axil_arready = 1'b1;
         @(negedge aclk);
         m_axil_arready = 1'b0;
         if (!m_axil_rready) ok = 0;
         m_axil_rvalid = 1'b1; m_axil_rdata = data; m_axil_rresp = 2'b00;
         @(negedge aclk);
         m_axil_rvalid = 1'b0; m_axil_rdata = '0;
      end
   endtask

   task automatic test_reset;
      areset = 1'b1;
      @(negedge aclk);
      n_tests++;
      if (ep_status !== 32'h0000_0080) begin n_fail++;
         $display("FAIL reset_status: got %h expected %h", ep_status, 32'h0000_0080); end
      n_tests++;
      if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 5'b0) begin
         n_fail++; $display("FAIL reset_handshake: got %b expected 00000",
            {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready}); end
      n_tests++;
      if ({m_axil_awaddr, m_axil_araddr, m_axil_wdata, po_data} !== 128'd0) begin n_fail++;
         $display("FAIL reset_addr_data: got %h %h %h %h expected all 0",
            m_axil_awaddr, m_axil_araddr, m_axil_wdata, po_data); end
      areset = 1'b0;
      @(negedge aclk);
   endtask

   task automatic test_write_burst;
      logic [31:0] a, d; logic br; bit ok;
      pulse(32'h4);
      for (int i = 0; i < 4; i++) push_pi(32'h11 * (i + 1));
      ep_addr = 32'h1000; ep_count = 16'd4; ep_incr = 1'b1;
      pulse(32'h1);
      n_tests++;
      if (!(m_axil_awvalid === 1'b1 && m_axil_wvalid === 1'b1 && m_axil_wstrb === 4'hF)) begin
         n_fail++; $display("FAIL wr_first_issue: aw=%b w=%b strb=%h expected 1 1 f",
            m_axil_awvalid, m_axil_wvalid, m_axil_wstrb); end
      for (int i = 0; i < 4; i++) begin
         serve_write(2'b00, a, d, br, ok);
         n_tests++;
         if (!ok || !br || a !== 32'h1000 + 32'(4 * i) || d !== 32'(32'h11 * (i + 1))) begin
            n_fail++; $display("FAIL wr_beat%0d: ok=%0d bready=%b addr=%h data=%h expected addr %h data %h",
               i, ok, br, a, d, 32'h1000 + 32'(4 * i), 32'(32'h11 * (i + 1))); end
      end
      n_tests++;
      if (ep_status !== 32'h0004_0082) begin n_fail++;
         $display("FAIL wr_status: got %h expected %h", ep_status, 32'h0004_0082); end
   endtask

   task automatic test_read_burst;
      logic [31:0] a, d; bit ok;
      logic [31:0] rd [3];
      rd[0] = 32'h0000_000A; rd[1] = 32'h0000_000B; rd[2] = 32'h0000_000C;
      pulse(32'h4);
      ep_addr = 32'h20; ep_count = 16'd3; ep_incr = 1'b0;
      pulse(32'h2);
      n_tests++;
      if (m_axil_arvalid !== 1'b1 || m_axil_awvalid !== 1'b0) begin n_fail++;
         $display("FAIL rd_first_issue: ar=%b aw=%b expected 1 0", m_axil_arvalid, m_axil_awvalid); end
      for (int i = 0; i < 3; i++) begin
         serve_read(rd[i], a, ok);
         n_tests++;
         if (!ok || a !== 32'h20) begin n_fail++;
            $display("FAIL rd_beat%0d: ok=%0d addr=%h expected 00000020", i, ok, a); end
      end
      n_tests++;
      if (ep_status[31:16] !== 16'd3 || ep_status[1:0] !== 2'b10) begin n_fail++;
         $display("FAIL rd_status: got %h expected beats 3 done 1", ep_status); end
      for (int i = 0; i < 3; i++) begin
         pop_po(d);
         n_tests++;
         if (d !== rd[i]) begin n_fail++;
            $display("FAIL rd_pop%0d: got %h expected %h", i, d, rd[i]); end
      end
      n_tests++;
      if (ep_status[7] !== 1'b1) begin n_fail++;
         $display("FAIL rd_po_empty: got %b expected 1", ep_status[7]); end
   endtask

   task automatic test_po_backpressure;
      logic [31:0] a, d; bit ok; int seen;
      pulse(32'h4);
      ep_addr = 32'h100; ep_count = 16'd5; ep_incr = 1'b1; ep_timeout = 32'd0;
      pulse(32'h2);
      for (int i = 0; i < FD; i++) begin
         serve_read(32'h5000 + 32'(i), a, ok);
         n_tests++;
         if (!ok || a !== 32'h100 + 32'(4 * i)) begin n_fail++;
            $display("FAIL bp_beat%0d: ok=%0d addr=%h expected %h", i, ok, a, 32'h100 + 32'(4 * i)); end
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (m_axil_arvalid) seen++;
         @(negedge aclk);
      end
      n_tests++;
      if (seen != 0 || ep_status[0] !== 1'b1) begin n_fail++;
         $display("FAIL bp_stall: arvalid cycles=%0d busy=%b expected 0 1", seen, ep_status[0]); end
      pop_po(d);
      n_tests++;
      if (d !== 32'h5000 || m_axil_arvalid !== 1'b1) begin n_fail++;
         $display("FAIL bp_resume: pop=%h arvalid=%b expected 00005000 1", d, m_axil_arvalid); end
      serve_read(32'h5000 + 32'(FD), a, ok);
      n_tests++;
      if (!ok || a !== 32'h110 || ep_status[31:16] !== 16'd5 || ep_status[1] !== 1'b1) begin n_fail++;
         $display("FAIL bp_last: ok=%0d addr=%h status=%h expected addr 00000110 beats 5 done",
            ok, a, ep_status); end
      for (int i = 1; i <= FD; i++) begin
         pop_po(d);
         n_tests++;
         if (d !== 32'h5000 + 32'(i)) begin n_fail++;
            $display("FAIL bp_pop%0d: got %h expected %h", i, d, 32'h5000 + 32'(i)); end
      end
   endtask

   task automatic test_write_error;
      logic [31:0] a, d; logic br; bit ok; int seen;
      pulse(32'h4);
      push_pi(32'h101); push_pi(32'h202); push_pi(32'h303);
      ep_addr = 32'h200; ep_count = 16'd3; ep_incr = 1'b1;
      pulse(32'h1);
      serve_write(2'b00, a, d, br, ok);
      n_tests++;
      if (!ok || a !== 32'h200 || d !== 32'h101) begin n_fail++;
         $display("FAIL err_beat0: ok=%0d addr=%h data=%h expected 00000200 00000101", ok, a, d); end
      serve_write(2'b10, a, d, br, ok);
      n_tests++;
      if (!ok || a !== 32'h204 || d !== 32'h202) begin n_fail++;
         $display("FAIL err_beat1: ok=%0d addr=%h data=%h expected 00000204 00000202", ok, a, d); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (m_axil_awvalid) seen++;
         @(negedge aclk);
      end
      n_tests++;
      if (seen != 0) begin n_fail++;
         $display("FAIL err_no_third_aw: awvalid cycles=%0d expected 0", seen); end
      n_tests++;
      if (ep_status !== 32'h0002_00A6) begin n_fail++;
         $display("FAIL err_status: got %h expected %h", ep_status, 32'h0002_00A6); end
      pulse(32'h4);
      n_tests++;
      if (ep_status !== 32'h0002_0080) begin n_fail++;
         $display("FAIL err_clear: got %h expected %h", ep_status, 32'h0002_0080); end
   endtask

   task automatic test_timeout;
      int hi;
      pulse(32'h4);
      push_pi(32'hDEAD_0001);
      ep_addr = 32'h300; ep_count = 16'd1; ep_incr = 1'b1; ep_timeout = 32'd8;
      pulse(32'h1);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_axil_awvalid) hi++;
         @(negedge aclk);
      end
      n_tests++;
      if (hi != 8) begin n_fail++;
         $display("FAIL tmo_aw_cycles: got %0d expected 8", hi); end
      n_tests++;
      if (ep_status !== 32'h0000_008A || m_axil_wvalid !== 1'b0) begin n_fail++;
         $display("FAIL tmo_status: got %h wvalid=%b expected %h 0", ep_status, m_axil_wvalid,
            32'h0000_008A); end
      ep_timeout = 32'd0;
      pulse(32'h4);
   endtask

   task automatic test_zero_count;
      int seen;
      ep_addr = 32'h500; ep_count = 16'd0; ep_incr = 1'b1;
      pulse(32'h1);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (m_axil_awvalid || m_axil_arvalid) seen++;
         @(negedge aclk);
      end
      n_tests++;
      if (seen != 0 || ep_status !== 32'h0000_0082) begin n_fail++;
         $display("FAIL zero_count: valid cycles=%0d status=%h expected 0 %h", seen, ep_status,
            32'h0000_0082); end
   endtask

   task automatic test_fifo_flags;
      pulse(32'h4);
      for (int i = 0; i < FD + 1; i++) push_pi(32'h7000 + 32'(i));
      n_tests++;
      if (ep_status[8] !== 1'b1 || ep_status[6] !== 1'b1) begin n_fail++;
         $display("FAIL fifo_ovf: ovf=%b full=%b expected 1 1", ep_status[8], ep_status[6]); end
      pulse(32'h4);
      n_tests++;
      if (ep_status[8] !== 1'b0 || ep_status[6] !== 1'b0) begin n_fail++;
         $display("FAIL fifo_flush: ovf=%b full=%b expected 0 0", ep_status[8], ep_status[6]); end
   endtask

   task automatic test_wrap_and_priority;
      logic [31:0] a, d; logic br; bit ok;
      pulse(32'h4);
      push_pi(32'hCAFE_0001); push_pi(32'hCAFE_0002);
      ep_addr = 32'hFFFF_FFFC; ep_count = 16'd2; ep_incr = 1'b1;
      pulse(32'h3);
      n_tests++;
      if (m_axil_awvalid !== 1'b1 || m_axil_arvalid !== 1'b0) begin n_fail++;
         $display("FAIL both_trig: aw=%b ar=%b expected 1 0", m_axil_awvalid, m_axil_arvalid); end
      serve_write(2'b00, a, d, br, ok);
      n_tests++;
      if (!ok || a !== 32'hFFFF_FFFC || d !== 32'hCAFE_0001) begin n_fail++;
         $display("FAIL wrap_beat0: ok=%0d addr=%h data=%h expected fffffffc cafe0001", ok, a, d); end
      serve_write(2'b00, a, d, br, ok);
      n_tests++;
      if (!ok || a !== 32'h0000_0000 || d !== 32'hCAFE_0002) begin n_fail++;
         $display("FAIL wrap_beat1: ok=%0d addr=%h data=%h expected 00000000 cafe0002", ok, a, d); end
      n_tests++;
      if (ep_status !== 32'h0002_0082) begin n_fail++;
         $display("FAIL wrap_status: got %h expected %h", ep_status, 32'h0002_0082); end
   endtask

   task automatic test_reset_mid_burst;
      logic [31:0] a, d; logic br; bit ok; int seen;
      pulse(32'h4);
      push_pi(32'hBEEF_0001); push_pi(32'hBEEF_0002);
      ep_addr = 32'h400; ep_count = 16'd2; ep_incr = 1'b1;
      pulse(32'h1);
      serve_write(2'b00, a, d, br, ok);
      n_tests++;
      if (!ok || m_axil_awvalid !== 1'b1) begin n_fail++;
         $display("FAIL rst_pre: ok=%0d awvalid=%b expected 1 1", ok, m_axil_awvalid); end
      areset = 1'b1;
      @(negedge aclk);
      n_tests++;
      if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 5'b0 ||
          m_axil_awaddr !== 32'd0 || m_axil_wdata !== 32'd0 || ep_status !== 32'h0000_0080) begin
         n_fail++; $display("FAIL rst_mid: valids=%b awaddr=%h wdata=%h status=%h expected 0 0 0 00000080",
            {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready},
            m_axil_awaddr, m_axil_wdata, ep_status); end
      areset = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         if (m_axil_awvalid || m_axil_wvalid) seen++;
      end
      n_tests++;
      if (seen != 0) begin n_fail++;
         $display("FAIL rst_after: valid cycles=%0d expected 0", seen); end
   endtask

   initial begin
      areset = 1'b1; ep_addr = '0; ep_count = '0; ep_incr = 1'b0; ep_timeout = '0;
      ep_trigger = '0; pi_data = '0; pi_write = 1'b0; po_read = 1'b0;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = 2'b00; m_axil_bvalid = 1'b0;
      m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;
      repeat (3) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      test_reset;
      test_write_burst;
      test_read_burst;
      test_po_backpressure;
      test_write_error;
      test_timeout;
      test_zero_count;
      test_fifo_flags;
      test_wrap_and_priority;
      test_reset_mid_burst;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
